channel_sequencer: RTL and testbench
====================================

Name: channel_sequencer

Overview:
- Two-channel controller FSM that produces the 3-bit status codes F1 and F2 consumed by the LED decoder directly downstream.
- Each channel runs request → active → drain cycles. The channels share one actuator, so at most one channel is active or draining at a time.
- A round-robin arbiter resolves contention, and a per-channel fault input latches a fault code until it is cleared.

Parameters:
- ACT_CYCLES, 8, cycles a granted channel stays ACTIVE (≥1)
- DRAIN_CYCLES, 3, cycles spent in DRAIN after ACTIVE (≥1)
- WAIT_MAX, 16, watchdog limit in cycles for REQ wait (used only with SEQ_WATCHDOG_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  req[i]: channel i requests service (level)
- stop  in  2  stop[i]: early termination of ACTIVE for channel i
- fault  in  2  fault[i]: sensor fault for channel i
- clr  in  2  clr[i]: clears FAULT for channel i
- F1  out  3  channel 0 state code (registered)
- F2  out  3  channel 1 state code (registered)
- busy  out  1  high when any channel is ACTIVE or DRAIN (registered)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high and is sampled only on the rising edge of clk.
- State codes, shared by both channels: IDLE=000, REQ=001, ACTIVE=011, DRAIN=100, FAULT=110. The 3-bit values 010, 101 and 111 are never driven.
- F1 and F2 are the state registers themselves: zero combinational logic on the outputs and one cycle of latency from the input sample.
- Reset values: F1=F2=000, busy=0, both counters=0, last_served=1 (so channel 0 wins the first tie).
- A reset asserted mid-cycle of any state forces IDLE on the next edge, with no drain completion.
- Transitions per channel, evaluated every edge, listed in priority order:
  - IDLE: req[i]=1 → REQ.
  - REQ: req[i]=0 → IDLE (withdrawn). Otherwise, grant[i]=1 → ACTIVE and the counter loads ACT_CYCLES-1.
  - ACTIVE: fault[i]=1 → FAULT. Otherwise, stop[i]=1 or counter==0 → DRAIN and the counter loads DRAIN_CYCLES-1. Otherwise the counter decrements.
  - ACTIVE length: with no stop or fault, ACTIVE lasts exactly ACT_CYCLES cycles.
  - DRAIN: counter==0 → IDLE, otherwise decrement. fault is ignored in DRAIN.
  - FAULT: clr[i]=1 → IDLE, otherwise hold. req is ignored.
  - fault[i] in IDLE or REQ → FAULT.
- Arbiter (combinational, inside the top level):
  - Resource is free when neither channel is in ACTIVE or DRAIN.
  - grant[i] = free & state[i]==REQ & (other channel not in REQ, or last_served != i).
  - On a grant, last_served ← i.
  - No grant is issued in the same cycle the resource frees: a DRAIN→IDLE transition and a REQ→ACTIVE transition never share an edge.
- busy is registered from the next-state values: busy=1 in the same cycle that F1 or F2 shows 011 or 100.
- Counter width is $clog2(max(ACT_CYCLES, DRAIN_CYCLES, WAIT_MAX)+1). The counter never wraps.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro defined: each channel has a wait counter, zeroed on entry to REQ and incremented each cycle spent in REQ. When it reaches WAIT_MAX-1 with no grant, the channel goes to FAULT. A grant on the same edge takes priority over the watchdog.
- Without the macro: the wait counter and WAIT_MAX logic are absent, and REQ waits indefinitely.

Decomposition:
- Package seq_pkg holds: the state localparams (ST_IDLE, ST_REQ, ST_ACTIVE, ST_DRAIN, ST_FAULT), the 3-bit state width constant, and the counter-width function.
- Sub-module channel_fsm holds one channel's state register, counter and optional watchdog.
  - Inputs: clk, rst, req, stop, fault, clr, grant.
  - Outputs: state[2:0] and an in_use flag.
- The top level instantiates channel_fsm twice and contains the arbiter, last_served and busy.

Test Plan (ACT_CYCLES=4, DRAIN_CYCLES=2, WAIT_MAX=5):
- Reset then req=01 held → F1: 000→001→011 (×4 cycles)→100 (×2)→000→001 repeats; F2 stays 000; busy high for 6 cycles per service.
- req=11 asserted on the same edge after reset → both go to 001. Ch0 is granted first (F1=011, F2=001). After ch0 drains, ch1 is granted, and then ch0 again.
- Ch0 ACTIVE, stop=01 on its 2nd active cycle → F1=100 on the next edge; DRAIN lasts 2 cycles; then 000.
- Ch1 ACTIVE, fault=10 pulse → F2=110 and is held with req still high. clr=10 → F2=000, then 001 on the next edge.
- rst pulsed for 1 cycle while ch0 is in DRAIN → next edge gives F1=F2=000 and busy=0; ch0 (req=01) re-enters 001 one cycle later.
- SEQ_WATCHDOG_EN, ch0 ACTIVE with ch1 requesting → F2 = 001 for 5 cycles, then 110, while ch0 is unaffected. Without the macro, F2 stays 001 until granted.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for channel_sequencer.
// Contents:
//   ST_W, state_t  - width and type of a channel state code
//   ST_*           - state codes decoded by the LED logic downstream
//   cnt_width()    - width of the per-channel cycle counters
package seq_pkg;

    localparam int unsigned ST_W = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'b000;
    localparam state_t ST_REQ    = 3'b001;
    localparam state_t ST_ACTIVE = 3'b011;
    localparam state_t ST_DRAIN  = 3'b100;
    localparam state_t ST_FAULT  = 3'b110;

    // Wide enough to hold the largest of the three cycle limits without wrapping.
    function automatic int unsigned cnt_width(input int unsigned act,
                                              input int unsigned drain,
                                              input int unsigned wmax);
        int unsigned m;
        m = (act > drain) ? act : drain;
        if (wmax > m) m = wmax;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/channel_sequencer_if.sv
// Bus bundle between the controller and its environment.
// Signals:
//   req, stop, fault, clr [1:0] - per-channel controls, bit i is channel i
//   F1, F2 [2:0]                - registered state codes of channel 0 / channel 1
//   busy                        - registered, high while any channel is ACTIVE or DRAIN
// Modports: master (environment side), slave (channel_sequencer side).
interface channel_sequencer_if;

    logic [1:0]              req;
    logic [1:0]              stop;
    logic [1:0]              fault;
    logic [1:0]              clr;
    logic [seq_pkg::ST_W-1:0] F1;
    logic [seq_pkg::ST_W-1:0] F2;
    logic                    busy;

    modport master (
        output req, stop, fault, clr,
        input  F1, F2, busy
    );

    modport slave (
        input  req, stop, fault, clr,
        output F1, F2, busy
    );

endinterface

// File: rtl/channel_sequencer_fsm.sv
// channel_fsm: one channel's request/active/drain/fault state machine.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req, stop, fault, clr, grant - channel controls and arbiter grant
//   state     - registered state code (the state register itself)
//   in_use    - next state is ACTIVE or DRAIN; the top registers it into busy
// Optional feature: SEQ_WATCHDOG_EN adds a REQ wait counter that faults the
// channel after WAIT_MAX cycles without a grant.
module channel_fsm
    import seq_pkg::*;
#(
    parameter int unsigned ACT_CYCLES   = 8,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned WAIT_MAX     = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req,
    input  logic   stop,
    input  logic   fault,
    input  logic   clr,
    input  logic   grant,
    output state_t state,
    output logic   in_use
);

    localparam int unsigned CW = cnt_width(ACT_CYCLES, DRAIN_CYCLES, WAIT_MAX);
    localparam logic [CW-1:0] ACT_LOAD   = CW'(ACT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    state_t        r_state;
    state_t        w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
`ifdef SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
    logic [CW-1:0] r_wait;
    logic [CW-1:0] w_wait_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef SEQ_WATCHDOG_EN
            r_wait  <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
`ifdef SEQ_WATCHDOG_EN
            r_wait  <= w_wait_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
`ifdef SEQ_WATCHDOG_EN
        w_wait_d  = r_wait;
`endif
        case (r_state)
            ST_IDLE: begin
                if (fault) begin
                    w_state_d = ST_FAULT;
                end else if (req) begin
                    w_state_d = ST_REQ;
`ifdef SEQ_WATCHDOG_EN
                    w_wait_d  = '0;
`endif
                end
            end
            ST_REQ: begin
                if (fault) begin
                    w_state_d = ST_FAULT;
                end else if (!req) begin
                    w_state_d = ST_IDLE;
                end else if (grant) begin
                    w_state_d = ST_ACTIVE;
                    w_cnt_d   = ACT_LOAD;
`ifdef SEQ_WATCHDOG_EN
                end else if (r_wait == WAIT_LAST) begin
                    w_state_d = ST_FAULT;
                end else begin
                    w_wait_d  = r_wait + ONE;
`endif
                end
            end
            ST_ACTIVE: begin
                if (fault) begin
                    w_state_d = ST_FAULT;
                    w_cnt_d   = '0;
                end else if (stop || (r_cnt == '0)) begin
                    w_state_d = ST_DRAIN;
                    w_cnt_d   = DRAIN_LOAD;
                end else begin
                    w_cnt_d   = r_cnt - ONE;
                end
            end
            ST_DRAIN: begin
                // Fault is deliberately ignored so the actuator always finishes draining.
                if (r_cnt == '0) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d   = r_cnt - ONE;
                end
            end
            ST_FAULT: begin
                if (clr) w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        state  = r_state;
        in_use = (w_state_d == ST_ACTIVE) || (w_state_d == ST_DRAIN);
    end

endmodule

// File: rtl/channel_sequencer.sv
// channel_sequencer: two-channel controller sharing one actuator.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - channel_sequencer_if.slave (req/stop/fault/clr in, F1/F2/busy out)
// Holds two channel_fsm instances, the round-robin arbiter, last_served and busy.
// Optional feature: SEQ_WATCHDOG_EN (REQ watchdog inside each channel_fsm).
module channel_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ACT_CYCLES   = 8,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned WAIT_MAX     = 16
) (
    input  logic                clk,
    input  logic                rst,
    channel_sequencer_if.slave  bus
);

    state_t     w_state [2];
    logic [1:0] w_in_use;
    logic [1:0] w_grant;
    logic       w_free;
    logic       r_last_served;
    logic       r_busy;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        channel_fsm #(
            .ACT_CYCLES   (ACT_CYCLES),
            .DRAIN_CYCLES (DRAIN_CYCLES),
            .WAIT_MAX     (WAIT_MAX)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .req    (bus.req[i]),
            .stop   (bus.stop[i]),
            .fault  (bus.fault[i]),
            .clr    (bus.clr[i]),
            .grant  (w_grant[i]),
            .state  (w_state[i]),
            .in_use (w_in_use[i])
        );
    end

    // Arbiter works on current states, so a channel leaving DRAIN frees the
    // actuator only from the following edge onward.
    always_comb begin
        w_free = (w_state[0] != ST_ACTIVE) && (w_state[0] != ST_DRAIN) &&
                 (w_state[1] != ST_ACTIVE) && (w_state[1] != ST_DRAIN);
        w_grant[0] = w_free && (w_state[0] == ST_REQ) &&
                     ((w_state[1] != ST_REQ) || (r_last_served != 1'b0));
        w_grant[1] = w_free && (w_state[1] == ST_REQ) &&
                     ((w_state[0] != ST_REQ) || (r_last_served != 1'b1));
    end

    // last_served only moves when the grant actually takes the channel to ACTIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            if (w_grant[0] && bus.req[0] && !bus.fault[0]) begin
                r_last_served <= 1'b0;
            end else if (w_grant[1] && bus.req[1] && !bus.fault[1]) begin
                r_last_served <= 1'b1;
            end
            r_busy <= |w_in_use;
        end
    end

    assign bus.F1   = w_state[0];
    assign bus.F2   = w_state[1];
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_channel_sequencer.sv
// Self-checking bench for channel_sequencer with ACT_CYCLES=4, DRAIN_CYCLES=2, WAIT_MAX=5.
module tb_channel_sequencer;

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [1:0] stop;
        logic [1:0] fault;
        logic [1:0] clr;
        logic [2:0] f1;
        logic [2:0] f2;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    channel_sequencer_if bus ();

    channel_sequencer #(
        .ACT_CYCLES   (4),
        .DRAIN_CYCLES (2),
        .WAIT_MAX     (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic [1:0] rq, input logic [1:0] sp,
                               input logic [1:0] ft, input logic [1:0] cl, input logic [2:0] e1,
                               input logic [2:0] e2, input logic eb);
        vec_t x;
        x = '{rst: r, req: rq, stop: sp, fault: ft, clr: cl, f1: e1, f2: e2, busy: eb};
        return x;
    endfunction

    task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] sp,
                        input logic [1:0] ft, input logic [1:0] cl);
        rst       = r;
        bus.req   = rq;
        bus.stop  = sp;
        bus.fault = ft;
        bus.clr   = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] e1, input logic [2:0] e2,
                       input logic eb);
        n_checks++;
        if (bus.F1 !== e1 || bus.F2 !== e2 || bus.busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got F1=%b F2=%b busy=%b, want F1=%b F2=%b busy=%b",
                     name, bus.F1, bus.F2, bus.busy, e1, e2, eb);
        end
    endtask

    initial begin
        bus.req = '0; bus.stop = '0; bus.fault = '0; bus.clr = '0;

        // rst req stop fault clr | F1 F2 busy
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0)); // reset
        tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0)); // ch0 service
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1)); // 1st active
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1)); // 2nd active
        tbl.push_back(v(0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, 1)); // stop
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0)); // ch1 fault
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 1));
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b110, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b110, 0)); // held
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000, 3'b000, 0)); // clr
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b110, 0)); // fault in REQ
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0)); // reset in DRAIN
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 1));
        tbl.push_back(v(1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 1));
        tbl.push_back(v(0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, 1)); // fault in DRAIN
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b100, 3'b000, 1));
        tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].stop, tbl[i].fault, tbl[i].clr);
            chk($sformatf("vec%0d", i), tbl[i].f1, tbl[i].f2, tbl[i].busy);
        end

`ifndef SEQ_WATCHDOG_EN
        // Tie after reset: ch0 wins first, then ch1, then ch0 again.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_req", 3'b001, 3'b001, 0);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_grant0", 3'b011, 3'b001, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_act0", 3'b011, 3'b001, 1);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_drain0", 3'b100, 3'b001, 1);
        end
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_free_gap", 3'b000, 3'b001, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_act1", 3'b001, 3'b011, 1);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_drain1", 3'b001, 3'b100, 1);
        end
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_gap1", 3'b001, 3'b000, 0);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("tie_regrant0", 3'b011, 3'b001, 1);
`endif

        // Ch1 waits while ch0 is ACTIVE: watchdog faults it after 5 REQ cycles.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00);
        step(0, 2'b01, 2'b00, 2'b00, 2'b00); chk("wd_req0", 3'b001, 3'b000, 0);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("wd_wait0", 3'b011, 3'b001, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("wd_wait", 3'b011, 3'b001, 1);
        end
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("wd_wait4", 3'b100, 3'b001, 1);
`ifdef SEQ_WATCHDOG_EN
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("wd_fault", 3'b100, 3'b110, 1);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("wd_fault_hold", 3'b000, 3'b110, 0);
`else
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("nowd_wait5", 3'b100, 3'b001, 1);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("nowd_gap", 3'b000, 3'b001, 0);
        step(0, 2'b11, 2'b00, 2'b00, 2'b00); chk("nowd_grant1", 3'b001, 3'b011, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
